mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (imem side) and the load/store requester (dmem side).
- Sits between the fetch/memory stages and the single memory/bus interface.
- Allows one outstanding transaction at a time and returns each response only to the requester that owns it.
- Data side has priority; a streak counter prevents fetch starvation.

Parameters:
- MAX_DSTREAK, 4: maximum consecutive data grants while an instruction request is waiting; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- imem_valid  in  1  fetch request pulse
- imem_instr  in  1  instruction-access flag
- imem_addr  in  32  fetch address
- imem_wdata  in  32  write data, always 0 from fetch
- imem_wstrb  in  4  write strobes
- imem_ready  out  1  fetch response valid
- imem_rdata  out  32  fetch response data
- dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb  in  1/1/32/32/4  data request, same meanings as the imem_* inputs
- dmem_ready  out  1  data response valid
- dmem_rdata  out  32  data response data
- mem_valid  out  1  request to memory
- mem_instr  out  1  forwarded instruction-access flag
- mem_addr  out  32  forwarded address
- mem_wdata  out  32  forwarded write data
- mem_wstrb  out  4  forwarded write strobes
- mem_ready  in  1  memory response valid
- mem_rdata  in  32  memory response data

Behaviour:
- Requester contract: each *_valid is a one-cycle pulse. A requester issues nothing further until it has seen its *_ready.
- Memory contract: memory holds a request sampled on mem_valid=1 and pulses mem_ready once. mem_ready may come in the same cycle as mem_valid (zero-wait) or any later cycle.
- State: fsm in {IDLE, BUSY_I, BUSY_D}.
  - ipend/dpend: one-entry request buffers, each holding instr, addr, wdata and wstrb.
  - dstreak: 4-bit counter.
- Effective request per side = pending buffer if set, else the live input.
- IDLE:
  - If any effective request exists, grant it combinationally in the same cycle: mem_valid=1 and mem_* = granted request fields. The fetch path therefore sees zero added latency.
  - Grant rule: data wins, unless an instruction request exists and dstreak==MAX_DSTREAK, in which case instruction wins.
  - If mem_ready=1 in that same cycle: forward the response, clear the granted pending bit, stay IDLE.
  - Otherwise: clear the granted pending bit, go to BUSY_I or BUSY_D.
  - The losing live request is latched into its pending buffer.
- BUSY_x:
  - mem_valid=0; mem_* fields are don't-care and are driven 0.
  - Live valids arriving in this state are latched into pending; a second pulse on a side that is already pending is a protocol violation.
  - On mem_ready=1: owner_ready=1, owner_rdata=mem_rdata, go to IDLE.
  - A newly arriving request in the completion cycle is latched and issued the next cycle.
- Non-owner outputs: *_ready=0 and *_rdata=0 always. In IDLE with no grant, both are 0.
- dstreak:
  - Increments (saturating at MAX_DSTREAK) on each data grant made while an instruction request was also effective.
  - Clears to 0 on any instruction grant.
  - Unchanged on an uncontested data grant.
- Reset (rst=0, asynchronous):
  - fsm=IDLE, ipend=dpend=0 with payloads 0, dstreak=0.
  - Outputs: mem_valid=0, mem_* fields 0, imem_ready=dmem_ready=0, rdata outputs 0.
  - A mem_ready arriving after reset while IDLE with no grant is dropped. Memory is expected to be reset with the arbiter.
- No combinational path from mem_ready to mem_valid.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst=0 asynchronously mid-BUSY_D, release, then no requests.
  - Response: all outputs 0 immediately on reset; fsm IDLE; a late mem_ready=1 with mem_rdata=0xDEADBEEF produces dmem_ready=0 and imem_ready=0.
- Zero-wait fetch:
  - Stimulus: imem_valid pulse with addr 0x80; memory returns mem_ready in the same cycle with rdata 0x00000013.
  - Response: mem_valid=1, mem_addr=0x80, imem_ready=1, imem_rdata=0x13 in the same cycle; fsm stays IDLE.
- Simultaneous requests:
  - Stimulus: imem addr 0x100 and dmem addr 0x2000 (wstrb 0xF, wdata 0x55) in the same cycle; memory has 2-cycle latency.
  - Response: data is issued first (mem_wstrb=0xF) and dmem_ready pulses after 2 cycles; the instruction request is then issued from ipend the next cycle and imem_ready pulses 2 cycles later.
- Starvation guard:
  - Stimulus: instruction request held pending; dmem pulses a new request on every completion; MAX_DSTREAK=4.
  - Response: exactly 4 data grants, then the instruction grant; dstreak returns to 0.
- Arrival at completion:
  - Stimulus: a dmem pulse lands in the same cycle mem_ready completes a fetch.
  - Response: imem_ready=1 in that cycle; the data request is issued the next cycle with mem_valid=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch (imem) and load/store (dmem) requesters.
// One transaction in flight; data has priority, bounded by a contested-grant streak counter.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic        imem_ready,
    output logic [31:0] imem_rdata,

    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t     fsm_q, fsm_d;
    logic       ipend_q, ipend_d;
    logic       dpend_q, dpend_d;
    req_t       ibuf_q, ibuf_d;
    req_t       dbuf_q, dbuf_d;
    logic [3:0] dstreak_q, dstreak_d;

    req_t ilive, dlive;
    req_t ieff_req, deff_req;
    req_t grant_req, mem_req;
    logic ieff, deff;
    logic grant_i, grant_d;
    logic i_owner, d_owner;

    // A buffered request always takes precedence over the live input of the same side.
    always_comb begin
        ilive     = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
        dlive     = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};
        ieff      = ipend_q | imem_valid;
        deff      = dpend_q | dmem_valid;
        ieff_req  = ipend_q ? ibuf_q : ilive;
        deff_req  = dpend_q ? dbuf_q : dlive;
        grant_i   = (fsm_q == IDLE) && ieff && (!deff || (dstreak_q == STREAK_MAX));
        grant_d   = (fsm_q == IDLE) && deff && !grant_i;
        grant_req = grant_i ? ieff_req : deff_req;
    end

    always_comb begin
        mem_valid  = grant_i | grant_d;
        mem_req    = mem_valid ? grant_req : '0;
        mem_instr  = mem_req.instr;
        mem_addr   = mem_req.addr;
        mem_wdata  = mem_req.wdata;
        mem_wstrb  = mem_req.wstrb;

        i_owner    = grant_i | (fsm_q == BUSY_I);
        d_owner    = grant_d | (fsm_q == BUSY_D);
        imem_ready = i_owner & mem_ready;
        dmem_ready = d_owner & mem_ready;
        imem_rdata = imem_ready ? mem_rdata : '0;
        dmem_rdata = dmem_ready ? mem_rdata : '0;
    end

    always_comb begin
        fsm_d     = fsm_q;
        ipend_d   = ipend_q;
        dpend_d   = dpend_q;
        ibuf_d    = ibuf_q;
        dbuf_d    = dbuf_q;
        dstreak_d = dstreak_q;

        // The losing side, or any arrival while busy, waits in its one-entry buffer.
        if (grant_i) begin
            ipend_d = 1'b0;
        end else if (imem_valid) begin
            ipend_d = 1'b1;
            ibuf_d  = ilive;
        end

        if (grant_d) begin
            dpend_d = 1'b0;
        end else if (dmem_valid) begin
            dpend_d = 1'b1;
            dbuf_d  = dlive;
        end

        case (fsm_q)
            IDLE: begin
                if (grant_i) begin
                    dstreak_d = '0;
                    if (!mem_ready) fsm_d = BUSY_I;
                end else if (grant_d) begin
                    if (ieff && (dstreak_q != STREAK_MAX)) dstreak_d = dstreak_q + 4'd1;
                    if (!mem_ready) fsm_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q     <= IDLE;
            ipend_q   <= 1'b0;
            dpend_q   <= 1'b0;
            ibuf_q    <= '0;
            dbuf_q    <= '0;
            dstreak_q <= '0;
        end else begin
            fsm_q     <= fsm_d;
            ipend_q   <= ipend_d;
            dpend_q   <= dpend_d;
            ibuf_q    <= ibuf_d;
            dbuf_q    <= dbuf_d;
            dstreak_q <= dstreak_d;
        end
    end

endmodule
